// File: rtl/pong_pkg.sv
// Shared types and helpers for the Pong game-state engine.
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE,
        PLAY,
        POINT,
        GAME_OVER
    } state_e;

    typedef logic [9:0]         coord_t;
    typedef logic signed [10:0] scoord_t;

    function automatic scoord_t clamp(
        input scoord_t v,
        input scoord_t lo,
        input scoord_t hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle: up/down arbitration, fixed step per frame, clamped travel.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int V_RES    = 480,
    parameter int PAD_H    = 40,
    parameter int PAD_STEP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    input  logic       down,
    output logic [9:0] pad_y
);

    localparam scoord_t LO   = scoord_t'(PAD_H / 2);
    localparam scoord_t HI   = scoord_t'(V_RES - 1 - PAD_H / 2);
    localparam scoord_t STEP = scoord_t'(PAD_STEP);
    localparam scoord_t MID  = scoord_t'(V_RES / 2);

    scoord_t y;
    scoord_t cand;
    scoord_t y_n;

    always_comb begin
        cand = y;
        unique case (1'b1)
            up && !down: cand = y - STEP;
            down && !up: cand = y + STEP;
            default:     cand = y;
        endcase
        y_n = clamp(cand, LO, HI);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y <= MID;
        end else if (en) begin
            y <= y_n;
        end
    end

    assign pad_y = y[9:0];

endmodule

// File: rtl/pong_game_engine.sv
// Pong game state: paddles, ball physics, scoring, serve delay and game-over.
module pong_game_engine
    import pong_pkg::*;
#(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int PAD_H        = 40,
    parameter int PAD_W        = 10,
    parameter int BALL_SZ      = 10,
    parameter int LEFT_PAD_X   = 90,
    parameter int RIGHT_PAD_X  = 540,
    parameter int PAD_STEP     = 4,
    parameter int SPEED_INIT   = 2,
    parameter int SPEED_MAX    = 6,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               l_up,
    input  logic               l_down,
    input  logic               r_up,
    input  logic               r_down,
    output logic [9:0]         ball_x,
    output logic [9:0]         ball_y,
    output logic [9:0]         l_pad_y,
    output logic [9:0]         r_pad_y,
    output logic [SCORE_W-1:0] l_score,
    output logic [SCORE_W-1:0] r_score,
    output logic               game_over,
    output logic               point_pulse
);

    if (WIN_SCORE >= (1 << SCORE_W)) begin : g_bad_win
        $error("WIN_SCORE does not fit in SCORE_W bits");
    end

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam scoord_t HALF   = scoord_t'(BALL_SZ / 2);
    localparam scoord_t CX     = scoord_t'(H_RES / 2);
    localparam scoord_t CY     = scoord_t'(V_RES / 2);
    localparam scoord_t Y_HI   = scoord_t'(V_RES - 1 - BALL_SZ / 2);
    localparam scoord_t X_HI   = scoord_t'(H_RES - 1 - BALL_SZ / 2);
    localparam scoord_t L_FACE = scoord_t'(LEFT_PAD_X + PAD_W);
    localparam scoord_t R_FACE = scoord_t'(RIGHT_PAD_X);
    localparam scoord_t REACH  = scoord_t'(PAD_H / 2 + BALL_SZ / 2);
    localparam scoord_t V0     = scoord_t'(SPEED_INIT);
    localparam scoord_t VMAX   = scoord_t'(SPEED_MAX);
    localparam scoord_t ONE    = 11'sd1;
    localparam scoord_t ZERO   = 11'sd0;

    function automatic scoord_t mag(input scoord_t v);
        return v[10] ? -v : v;
    endfunction

    function automatic scoord_t bump(input scoord_t v);
        return (mag(v) + ONE > VMAX) ? VMAX : mag(v) + ONE;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] s
    );
        return (s == '1) ? s : s + 1'b1;
    endfunction

    state_e             state, state_n;
    logic [CNT_W-1:0]   serve_cnt, cnt_n;
    scoord_t            bx, by, dx, dy;
    scoord_t            bx_n, by_n, dx_n, dy_n;
    logic [SCORE_W-1:0] ls_n, rs_n;
    logic               go_n, pp_n;
    logic               pad_en;

    scoord_t nx, ny, px, py, lp, rp;

    assign pad_en = frame_tick && (state != GAME_OVER);
    assign lp     = scoord_t'({1'b0, l_pad_y});
    assign rp     = scoord_t'({1'b0, r_pad_y});

    paddle_ctrl #(
        .V_RES   (V_RES),
        .PAD_H   (PAD_H),
        .PAD_STEP(PAD_STEP)
    ) u_l_pad (
        .clk  (clk),
        .reset(reset),
        .en   (pad_en),
        .up   (l_up),
        .down (l_down),
        .pad_y(l_pad_y)
    );

    paddle_ctrl #(
        .V_RES   (V_RES),
        .PAD_H   (PAD_H),
        .PAD_STEP(PAD_STEP)
    ) u_r_pad (
        .clk  (clk),
        .reset(reset),
        .en   (pad_en),
        .up   (r_up),
        .down (r_down),
        .pad_y(r_pad_y)
    );

    always_comb begin
        state_n = state;
        cnt_n   = serve_cnt;
        bx_n    = bx;
        by_n    = by;
        dx_n    = dx;
        dy_n    = dy;
        ls_n    = l_score;
        rs_n    = r_score;
        go_n    = game_over;
        pp_n    = 1'b0;
        nx      = bx + dx;
        ny      = by + dy;
        px      = nx;
        py      = clamp(ny, HALF, Y_HI);

        if (frame_tick) begin
            unique case (state)
                SERVE: begin
                    bx_n = CX;
                    by_n = CY;
                    if (serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                        cnt_n   = '0;
                        dx_n    = dx[10] ? -V0 : V0;
                        state_n = PLAY;
                    end else begin
                        cnt_n = serve_cnt + 1'b1;
                    end
                end
                PLAY: begin
                    if (ny <= HALF) dy_n = mag(dy);
                    else if (ny >= Y_HI) dy_n = -mag(dy);
                    // Paddles only catch a ball crossing their face this frame.
                    if (dx[10] && (nx - HALF <= L_FACE) &&
                        (bx - HALF > L_FACE) &&
                        (mag(py - lp) <= REACH)) begin
                        px   = L_FACE + HALF;
                        dx_n = bump(dx);
                    end else if ((dx > ZERO) && (nx + HALF >= R_FACE) &&
                                 (bx + HALF < R_FACE) &&
                                 (mag(py - rp) <= REACH)) begin
                        px   = R_FACE - HALF;
                        dx_n = -bump(dx);
                    end
                    if (px <= HALF) begin
                        rs_n    = sat_inc(r_score);
                        dx_n    = -V0;
                        pp_n    = 1'b1;
                        state_n = POINT;
                    end else if (px >= X_HI) begin
                        ls_n    = sat_inc(l_score);
                        dx_n    = V0;
                        pp_n    = 1'b1;
                        state_n = POINT;
                    end
                    bx_n = px;
                    by_n = py;
                end
                POINT: begin
                    bx_n = CX;
                    by_n = CY;
                    if (l_score == SCORE_W'(WIN_SCORE) ||
                        r_score == SCORE_W'(WIN_SCORE)) begin
                        state_n = GAME_OVER;
                        go_n    = 1'b1;
                    end else begin
                        state_n = SERVE;
                    end
                end
                GAME_OVER: begin
                    if (start) begin
                        ls_n    = '0;
                        rs_n    = '0;
                        cnt_n   = '0;
                        go_n    = 1'b0;
                        state_n = SERVE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SERVE;
            serve_cnt   <= '0;
            bx          <= CX;
            by          <= CY;
            dx          <= V0;
            dy          <= V0;
            l_score     <= '0;
            r_score     <= '0;
            game_over   <= 1'b0;
            point_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            serve_cnt   <= cnt_n;
            bx          <= bx_n;
            by          <= by_n;
            dx          <= dx_n;
            dy          <= dy_n;
            l_score     <= ls_n;
            r_score     <= rs_n;
            game_over   <= go_n;
            point_pulse <= pp_n;
        end
    end

    assign ball_x = bx[9:0];
    assign ball_y = by[9:0];

endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine: scripted rally through a full game.
module tb_pong_game_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic       l_up, l_down, r_up, r_down;
    logic [9:0] ball_x, ball_y, l_pad_y, r_pad_y;
    logic [3:0] l_score, r_score;
    logic       game_over, point_pulse;

    int checks = 0;
    int errors = 0;
    int k = 0;

    always #5 clk = ~clk;

    pong_game_engine dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .l_up       (l_up),
        .l_down     (l_down),
        .r_up       (r_up),
        .r_down     (r_down),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .l_pad_y    (l_pad_y),
        .r_pad_y    (r_pad_y),
        .l_score    (l_score),
        .r_score    (r_score),
        .game_over  (game_over),
        .point_pulse(point_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ball(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(ball_x), x);
        chk({tag, "_y"}, 32'(ball_y), y);
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance the rally to play frame 'to' (k counts PLAY frames).
    task automatic adv(input int to);
        while (k < to) begin
            tick();
            k++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_ball(tag, 320, 240);
        chk({tag, "_lpad"}, 32'(l_pad_y), 240);
        chk({tag, "_rpad"}, 32'(r_pad_y), 240);
        chk({tag, "_lsc"}, 32'(l_score), 0);
        chk({tag, "_rsc"}, 32'(r_score), 0);
        chk({tag, "_go"}, 32'(game_over), 0);
        chk({tag, "_pp"}, 32'(point_pulse), 0);
    endtask

    initial begin
        reset = 1'b1;
        frame_tick = 1'b0;
        start = 1'b0;
        l_up = 1'b0; l_down = 1'b0; r_up = 1'b0; r_down = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        // Serve hold; left presses both keys, right walks to the bottom.
        l_up = 1'b1; l_down = 1'b1; r_down = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            chk_ball("serve", 320, 240);
        end
        chk("both_keys_lpad", 32'(l_pad_y), 240);
        chk("rpad_bottom", 32'(r_pad_y), 459);
        l_up = 1'b0; l_down = 1'b0; r_down = 1'b0;

        // Point 1: right return, bottom wall, left return, top wall, right miss.
        k = 0;
        adv(1);   chk_ball("p1_k1", 322, 242);
        adv(107); chk_ball("p1_k107", 534, 454);
        adv(108); chk_ball("rhit", 535, 456);
        adv(109); chk_ball("rhit_after", 532, 458);
        adv(117); chk_ball("bwall", 508, 474);
        adv(118); chk_ball("bwall_after", 505, 472);
        adv(199);
        l_up = 1'b1;
        adv(202);
        l_up = 1'b0;
        chk("lpad_up3", 32'(l_pad_y), 228);
        adv(251); chk_ball("lhit_before", 106, 206);
        adv(252); chk_ball("lhit", 105, 204);
        adv(253); chk_ball("lhit_after", 109, 202);
        adv(351); chk_ball("twall_before", 501, 6);
        adv(352); chk_ball("twall", 505, 5);
        adv(353); chk_ball("twall_after", 509, 7);
        l_down = 1'b1;
        adv(356);
        l_down = 1'b0;
        chk("lpad_back", 32'(l_pad_y), 240);
        adv(384);
        chk_ball("p1_k384", 633, 69);
        chk("p1_no_pp", 32'(point_pulse), 0);
        adv(385);
        chk("p1_pp", 32'(point_pulse), 1);
        chk("p1_lsc", 32'(l_score), 1);
        chk("p1_rsc", 32'(r_score), 0);
        @(negedge clk);
        chk("p1_pp_clear", 32'(point_pulse), 0);
        tick();
        chk_ball("p1_recentre", 320, 240);
        chk("p1_go", 32'(game_over), 0);

        // Point 2: serve goes right again, left pad at 240 misses.
        ticks(60);
        k = 0;
        adv(1);   chk_ball("p2_k1", 322, 242);
        adv(108); chk_ball("p2_rhit", 535, 456);
        adv(252); chk_ball("p2_pass", 103, 204);
        adv(284); chk_ball("p2_k284", 7, 140);
        adv(285);
        chk("p2_pp", 32'(point_pulse), 1);
        chk("p2_rsc", 32'(r_score), 1);
        chk("p2_lsc", 32'(l_score), 1);
        tick();

        // Point 3: serve toward the left; right player holds up 200 frames.
        r_up = 1'b1;
        ticks(60);
        k = 0;
        adv(1);   chk_ball("p3_k1", 318, 238);
        adv(140); chk_ball("p3_k140", 40, 49);
        r_up = 1'b0;
        chk("rpad_top", 32'(r_pad_y), 20);
        adv(157); chk_ball("p3_k157", 6, 83);
        adv(158);
        chk("p3_pp", 32'(point_pulse), 1);
        chk("p3_rsc", 32'(r_score), 2);
        tick();

        // Points 4..10 all end with the left player missing on frame 158.
        for (int p = 4; p <= 10; p++) begin
            ticks(60 + 158);
            chk("pN_pp", 32'(point_pulse), 1);
            chk("pN_rsc", 32'(r_score), p - 1);
            tick();
            chk("pN_go", 32'(game_over), (p == 10) ? 1 : 0);
        end
        chk("final_lsc", 32'(l_score), 1);
        chk_ball("over_centre", 320, 240);

        // Game over freezes paddles and ball until start.
        l_up = 1'b1; r_down = 1'b1;
        ticks(5);
        l_up = 1'b0; r_down = 1'b0;
        chk("frz_lpad", 32'(l_pad_y), 240);
        chk("frz_rpad", 32'(r_pad_y), 20);
        chk_ball("frz", 320, 240);
        chk("frz_go", 32'(game_over), 1);
        chk("frz_rsc", 32'(r_score), 9);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_lsc", 32'(l_score), 0);
        chk("restart_rsc", 32'(r_score), 0);
        chk("restart_go", 32'(game_over), 0);

        // Reset in the middle of a rally, between frame ticks.
        r_down = 1'b1;
        ticks(10);
        r_down = 1'b0;
        chk("rpad_60", 32'(r_pad_y), 60);
        ticks(50);
        k = 0;
        adv(3);
        chk_ball("pre_rst", 314, 234);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        ticks(60);
        chk_ball("post_rst_serve", 320, 240);
        tick();
        chk_ball("post_rst_k1", 322, 242);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
